dc_tagcheck_rrip: RTL and testbench

Parametrised set-associative tag-check stage for the L1 data cache. It holds the tag/state/RRPV array in flops, takes one lookup, fill or invalidate per cycle, and returns the result one cycle later: hit flag, hit way, coherence state, and an SRRIP victim with its tag. It sits between the DC request decode and the data bank. It supersedes the fixed 4-way, 18-bit tag checker with configurable ways, sets, state width and RRPV width.

---
 rtl/dc_tagcheck_pkg.sv | 33 +++
 rtl/dc_rrip_victim.sv | 52 +++++
 rtl/dc_tagcheck_rrip.sv | 186 ++++++++++++++++++
 tb/tb_dc_tagcheck_rrip.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_tagcheck_pkg.sv
// Shared definitions for the L1 data-cache tag-check stage: request opcodes,
// RRPV policy constants and the per-way array entry layout.
package dc_tagcheck_pkg;

    localparam logic [1:0] DC_OP_LOOKUP = 2'd0;
    localparam logic [1:0] DC_OP_FILL   = 2'd1;
    localparam logic [1:0] DC_OP_INV    = 2'd2;
    localparam logic [1:0] DC_OP_RSVD   = 2'd3;

    localparam int DC_TAG_BITS   = 18;
    localparam int DC_STATE_BITS = 3;
    localparam int DC_RRPV_BITS  = 2;

    // Entry layout at the default geometry; the top builds the same field order
    // at whatever widths it is parameterised to.
    typedef struct packed {
        logic                     valid;
        logic [DC_TAG_BITS-1:0]   tag;
        logic [DC_STATE_BITS-1:0] state;
        logic [DC_RRPV_BITS-1:0]  rrpv;
    } dc_entry_t;

    localparam int DC_RRPV_HIT = 0;

    function automatic int dc_rrpv_max(input int rrpv_bits);
        return (1 << rrpv_bits) - 1;
    endfunction

    function automatic int dc_rrpv_insert(input int rrpv_bits);
        return (1 << rrpv_bits) - 2;
    endfunction

endpackage

// File: rtl/dc_rrip_victim.sv
// SRRIP victim picker for one set: lowest invalid way, else lowest way holding
// the set's maximum RRPV; also reports the increment that ages the set to max.
module dc_rrip_victim
    import dc_tagcheck_pkg::*;
#(
    parameter  int WAYS      = 4,
    parameter  int RRPV_BITS = 2,
    localparam int WAY_BITS  = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]                way_valid,
    input  logic [WAYS-1:0][RRPV_BITS-1:0] way_rrpv,
    output logic [WAY_BITS-1:0]            victim_way,
    output logic [RRPV_BITS-1:0]           max_rrpv,
    output logic [RRPV_BITS-1:0]           age_inc
);

    localparam logic [RRPV_BITS-1:0] RRPV_MAX = RRPV_BITS'(dc_rrpv_max(RRPV_BITS));

    logic                found_inv;
    logic                found_max;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] max_way;

    always_comb begin
        max_rrpv = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_rrpv[w] > max_rrpv) begin
                max_rrpv = way_rrpv[w];
            end
        end
        age_inc = RRPV_MAX - max_rrpv;
    end

    always_comb begin
        found_inv = 1'b0;
        inv_way   = '0;
        found_max = 1'b0;
        max_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!way_valid[w] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
            if ((way_rrpv[w] == max_rrpv) && !found_max) begin
                found_max = 1'b1;
                max_way   = WAY_BITS'(w);
            end
        end
        victim_way = found_inv ? inv_way : max_way;
    end

endmodule

// File: rtl/dc_tagcheck_rrip.sv
// L1 data-cache tag-check stage: flop-based tag/state/RRPV array with SRRIP
// replacement, one request per cycle and a single registered result slot.
module dc_tagcheck_rrip
    import dc_tagcheck_pkg::*;
#(
    parameter  int ADDR_BITS  = 29,
    parameter  int LINE_BITS  = 6,
    parameter  int SETS       = 32,
    parameter  int WAYS       = 4,
    parameter  int STATE_BITS = 3,
    parameter  int RRPV_BITS  = 2,
    localparam int IDX_BITS   = $clog2(SETS),
    localparam int TAG_BITS   = ADDR_BITS - LINE_BITS - IDX_BITS,
    localparam int WAY_BITS   = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_retry,
    input  logic [1:0]            req_op,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [STATE_BITS-1:0] req_state,
    output logic                  ack_valid,
    input  logic                  ack_retry,
    output logic                  ack_hit,
    output logic [WAY_BITS-1:0]   ack_way,
    output logic [STATE_BITS-1:0] ack_state,
    output logic [WAY_BITS-1:0]   ack_victim_way,
    output logic                  ack_victim_valid,
    output logic [TAG_BITS-1:0]   ack_victim_tag
);

    localparam logic [RRPV_BITS-1:0] RRPV_MAX    = RRPV_BITS'(dc_rrpv_max(RRPV_BITS));
    localparam logic [RRPV_BITS-1:0] RRPV_INSERT = RRPV_BITS'(dc_rrpv_insert(RRPV_BITS));
    localparam logic [RRPV_BITS-1:0] RRPV_HIT    = RRPV_BITS'(DC_RRPV_HIT);

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [STATE_BITS-1:0] state;
        logic [RRPV_BITS-1:0]  rrpv;
    } entry_t;

    entry_t arr [SETS][WAYS];
    entry_t set_rd [WAYS];

    logic [TAG_BITS-1:0]            req_tag;
    logic [IDX_BITS-1:0]            req_idx;
    logic                           unused_offset;
    logic                           accept;
    logic                           hit;
    logic [WAY_BITS-1:0]            hit_way;
    logic [WAYS-1:0]                way_valid;
    logic [WAYS-1:0][RRPV_BITS-1:0] way_rrpv;
    logic [WAY_BITS-1:0]            victim_way;
    logic [RRPV_BITS-1:0]           max_rrpv;
    logic [RRPV_BITS-1:0]           age_inc;
    logic [RRPV_BITS-1:0]           aged_rrpv [WAYS];
    logic [RRPV_BITS:0]             age_sum;
    logic [WAY_BITS-1:0]            next_ack_way;
    logic [STATE_BITS-1:0]          next_ack_state;

    assign req_tag       = req_addr[ADDR_BITS-1 -: TAG_BITS];
    assign req_idx       = req_addr[LINE_BITS +: IDX_BITS];
    assign unused_offset = ^req_addr[LINE_BITS-1:0];

    assign req_retry = ack_valid && ack_retry;
    assign accept    = req_valid && !req_retry;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            set_rd[w]    = arr[req_idx][w];
            way_valid[w] = set_rd[w].valid;
            way_rrpv[w]  = set_rd[w].rrpv;
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_rd[w].valid && (set_rd[w].tag == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    dc_rrip_victim #(
        .WAYS      (WAYS),
        .RRPV_BITS (RRPV_BITS)
    ) u_victim (
        .way_valid  (way_valid),
        .way_rrpv   (way_rrpv),
        .victim_way (victim_way),
        .max_rrpv   (max_rrpv),
        .age_inc    (age_inc)
    );

    // Ways already at the set maximum land exactly on RRPV_MAX; everything
    // else gets the same increment, clamped so the counter can never wrap.
    always_comb begin
        age_sum = '0;
        for (int w = 0; w < WAYS; w++) begin
            age_sum = {1'b0, way_rrpv[w]} + {1'b0, age_inc};
            if ((way_rrpv[w] == max_rrpv) || age_sum[RRPV_BITS] || (age_sum[RRPV_BITS-1:0] > RRPV_MAX)) begin
                aged_rrpv[w] = RRPV_MAX;
            end else begin
                aged_rrpv[w] = age_sum[RRPV_BITS-1:0];
            end
        end
    end

    always_comb begin
        next_ack_way   = '0;
        next_ack_state = '0;
        if (hit) begin
            next_ack_way   = hit_way;
            next_ack_state = set_rd[hit_way].state;
        end else if (req_op == DC_OP_FILL) begin
            next_ack_way = victim_way;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    arr[s][w] <= '{valid: 1'b0, tag: '0, state: '0, rrpv: RRPV_MAX};
                end
            end
        end else if (accept) begin
            case (req_op)
                DC_OP_LOOKUP: begin
                    if (hit) begin
                        arr[req_idx][hit_way].rrpv <= RRPV_HIT;
                    end
                end
                DC_OP_FILL: begin
                    if (hit) begin
                        arr[req_idx][hit_way].state <= req_state;
                        arr[req_idx][hit_way].rrpv  <= RRPV_HIT;
                    end else begin
                        for (int w = 0; w < WAYS; w++) begin
                            arr[req_idx][w].rrpv <= aged_rrpv[w];
                        end
                        // Later assignment to the victim overrides its aged RRPV.
                        arr[req_idx][victim_way] <= '{valid: 1'b1, tag: req_tag,
                                                      state: req_state, rrpv: RRPV_INSERT};
                    end
                end
                DC_OP_INV: begin
                    if (hit) begin
                        arr[req_idx][hit_way].valid <= 1'b0;
                        arr[req_idx][hit_way].rrpv  <= RRPV_MAX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_valid        <= 1'b0;
            ack_hit          <= 1'b0;
            ack_way          <= '0;
            ack_state        <= '0;
            ack_victim_way   <= '0;
            ack_victim_valid <= 1'b0;
            ack_victim_tag   <= '0;
        end else if (accept) begin
            ack_valid        <= 1'b1;
            ack_hit          <= hit;
            ack_way          <= next_ack_way;
            ack_state        <= next_ack_state;
            ack_victim_way   <= victim_way;
            ack_victim_valid <= set_rd[victim_way].valid;
            ack_victim_tag   <= set_rd[victim_way].tag;
        end else if (ack_valid && !ack_retry) begin
            ack_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_tagcheck_rrip.sv
// Scoreboard bench for dc_tagcheck_rrip: a reference array model predicts each
// accepted request's result, which is checked every cycle until it drains.
module tb_dc_tagcheck_rrip;
    import dc_tagcheck_pkg::*;

    localparam int ADDR_BITS = 29;
    localparam int LINE_BITS = 6;
    localparam int SETS      = 32;
    localparam int WAYS      = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid;
    logic        req_retry;
    logic [1:0]  req_op;
    logic [28:0] req_addr;
    logic [2:0]  req_state;
    logic        ack_valid;
    logic        ack_retry;
    logic        ack_hit;
    logic [1:0]  ack_way;
    logic [2:0]  ack_state;
    logic [1:0]  ack_victim_way;
    logic        ack_victim_valid;
    logic [17:0] ack_victim_tag;

    dc_tagcheck_rrip #(
        .ADDR_BITS  (ADDR_BITS),
        .LINE_BITS  (LINE_BITS),
        .SETS       (SETS),
        .WAYS       (WAYS),
        .STATE_BITS (DC_STATE_BITS),
        .RRPV_BITS  (DC_RRPV_BITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_retry        (req_retry),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_state        (req_state),
        .ack_valid        (ack_valid),
        .ack_retry        (ack_retry),
        .ack_hit          (ack_hit),
        .ack_way          (ack_way),
        .ack_state        (ack_state),
        .ack_victim_way   (ack_victim_way),
        .ack_victim_valid (ack_victim_valid),
        .ack_victim_tag   (ack_victim_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [1:0]  way;
        logic [2:0]  state;
        logic [1:0]  vway;
        logic        vvalid;
        logic [17:0] vtag;
    } exp_t;

    exp_t      sb [$];
    dc_entry_t model [SETS][WAYS];
    int        errors = 0;
    int        checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [28:0] makeAddr(input logic [17:0] tag, input logic [4:0] idx);
        return {tag, idx, 6'h00};
    endfunction

    function automatic void clearModel();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                model[s][w] = '{valid: 1'b0, tag: '0, state: '0, rrpv: 2'd3};
            end
        end
    endfunction

    function automatic logic [1:0] modelVictim(input logic [4:0] idx);
        logic [1:0] vw;
        logic [1:0] mx;
        bit         found;
        found = 0;
        vw    = 2'd0;
        mx    = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !model[idx][w].valid) begin
                found = 1;
                vw    = 2'(w);
            end
            if (model[idx][w].rrpv > mx) mx = model[idx][w].rrpv;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!found && model[idx][w].rrpv == mx) vw = 2'(w);
        end
        return vw;
    endfunction

    // Predict the result of an accepted request and apply its array update.
    function automatic exp_t modelRequest(input logic [1:0] op, input logic [28:0] addr, input logic [2:0] st);
        exp_t       e;
        logic [4:0] idx;
        logic [17:0] tg;
        logic [1:0] hw;
        logic [1:0] vw;
        bit         hit;
        int         mx;
        int         sum;
        idx = addr[10:6];
        tg  = addr[28:11];
        hit = 0;
        hw  = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (model[idx][w].valid && model[idx][w].tag == tg) begin
                hit = 1;
                hw  = 2'(w);
            end
        end
        vw       = modelVictim(idx);
        e.hit    = hit;
        e.way    = hit ? hw : ((op == DC_OP_FILL) ? vw : 2'd0);
        e.state  = hit ? model[idx][hw].state : 3'd0;
        e.vway   = vw;
        e.vvalid = model[idx][vw].valid;
        e.vtag   = model[idx][vw].tag;
        if (op == DC_OP_LOOKUP && hit) begin
            model[idx][hw].rrpv = 2'd0;
        end else if (op == DC_OP_FILL && hit) begin
            model[idx][hw].state = st;
            model[idx][hw].rrpv  = 2'd0;
        end else if (op == DC_OP_FILL) begin
            mx = 0;
            for (int w = 0; w < WAYS; w++) if (int'(model[idx][w].rrpv) > mx) mx = int'(model[idx][w].rrpv);
            for (int w = 0; w < WAYS; w++) begin
                sum = int'(model[idx][w].rrpv) + (3 - mx);
                model[idx][w].rrpv = 2'((sum > 3) ? 3 : sum);
            end
            model[idx][vw] = '{valid: 1'b1, tag: tg, state: st, rrpv: 2'd2};
        end else if (op == DC_OP_INV && hit) begin
            model[idx][hw].valid = 1'b0;
            model[idx][hw].rrpv  = 2'd3;
        end
        return e;
    endfunction

    task automatic checkAck();
        if (sb.size() != 0) begin
            checkOutput("ack_valid", ack_valid, 1);
            checkOutput("ack_hit", ack_hit, sb[0].hit);
            checkOutput("ack_way", ack_way, sb[0].way);
            checkOutput("ack_state", ack_state, sb[0].state);
            checkOutput("ack_victim_way", ack_victim_way, sb[0].vway);
            checkOutput("ack_victim_valid", ack_victim_valid, sb[0].vvalid);
            checkOutput("ack_victim_tag", ack_victim_tag, sb[0].vtag);
        end else begin
            checkOutput("ack_valid_idle", ack_valid, 0);
        end
    endtask

    // Drive one cycle of stimulus; the result slot is checked after the edge.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [28:0] addr,
                                 input logic [2:0] st, input logic retry);
        bit had_ack;
        bit accept;
        req_valid = v;
        req_op    = op;
        req_addr  = addr;
        req_state = st;
        ack_retry = retry;
        had_ack   = (sb.size() != 0);
        #1;
        checkOutput("req_retry", req_retry, had_ack && retry);
        accept = v && !(had_ack && retry);
        if (had_ack && !retry) void'(sb.pop_front());
        if (accept) sb.push_back(modelRequest(op, addr, st));
        @(posedge clk);
        @(negedge clk);
        checkAck();
    endtask

    task automatic resetDut(input int cycles);
        reset     = 1'b0;
        req_valid = 1'b0;
        ack_retry = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_ack_valid", ack_valid, 0);
            checkOutput("rst_ack_hit", ack_hit, 0);
            checkOutput("rst_ack_way", ack_way, 0);
            checkOutput("rst_ack_state", ack_state, 0);
            checkOutput("rst_victim_way", ack_victim_way, 0);
            checkOutput("rst_victim_valid", ack_victim_valid, 0);
            checkOutput("rst_victim_tag", ack_victim_tag, 0);
            #1;
            checkOutput("rst_req_retry", req_retry, 0);
        end
        sb.delete();
        clearModel();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [17:0] tg;
        logic [4:0]  idx;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        req_state = '0;
        ack_retry = 1'b0;
        clearModel();
        resetDut(3);

        applyStimulus(1, DC_OP_LOOKUP, 29'h0001_0040, 3'd0, 0);

        for (int t = 0; t < 4; t++) applyStimulus(1, DC_OP_FILL, makeAddr(18'h100 + 18'(t), 5'd1), 3'b010, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h102, 5'd1), 3'd0, 0);

        // Aging and eviction of a full set with one recently referenced way.
        for (int t = 0; t < 4; t++) applyStimulus(1, DC_OP_FILL, makeAddr(18'h200 + 18'(t), 5'd3), 3'b010, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h201, 5'd3), 3'd0, 0);
        applyStimulus(1, DC_OP_FILL,   makeAddr(18'h2AA, 5'd3), 3'b001, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h200, 5'd3), 3'd0, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h2AA, 5'd3), 3'd0, 0);

        applyStimulus(1, DC_OP_FILL,   makeAddr(18'h202, 5'd3), 3'b100, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h202, 5'd3), 3'd0, 0);
        applyStimulus(1, DC_OP_FILL,   makeAddr(18'h2BB, 5'd3), 3'b011, 0);

        applyStimulus(1, DC_OP_INV,    makeAddr(18'h102, 5'd1), 3'd0, 0);
        applyStimulus(1, DC_OP_FILL,   makeAddr(18'h1FF, 5'd1), 3'b110, 0);
        applyStimulus(1, DC_OP_RSVD,   makeAddr(18'h100, 5'd1), 3'b111, 0);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h100, 5'd1), 3'd0, 0);

        // Stall with a request waiting, then release.
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h101, 5'd1), 3'd0, 0);
        repeat (3) applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h103, 5'd1), 3'd0, 1);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h103, 5'd1), 3'd0, 0);
        applyStimulus(0, DC_OP_LOOKUP, '0, 3'd0, 0);

        repeat (200) begin
            tg  = 18'h400 + 18'($urandom_range(0, 5));
            idx = 5'($urandom_range(6, 7));
            applyStimulus(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          makeAddr(tg, idx), 3'($urandom), logic'($urandom_range(0, 3) == 0));
        end
        applyStimulus(0, DC_OP_LOOKUP, '0, 3'd0, 0);

        // Reset while an ack is stalled and a request is waiting.
        applyStimulus(1, DC_OP_FILL, makeAddr(18'h300, 5'd5), 3'b010, 0);
        repeat (2) applyStimulus(1, DC_OP_FILL, makeAddr(18'h301, 5'd5), 3'b001, 1);
        resetDut(2);
        applyStimulus(1, DC_OP_LOOKUP, makeAddr(18'h300, 5'd5), 3'd0, 0);
        applyStimulus(0, DC_OP_LOOKUP, '0, 3'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
